// File: rtl/mem_burst_reader_pkg.sv
// Shared definitions for the memory burst reader: FSM encoding, legal read
// latencies and the width of word counters.
package mem_burst_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } rd_state_e;

    localparam int C_MAX_RD_LATENCY = 1;

    function automatic bit latency_is_legal(input int lat);
        return (lat >= 0) && (lat <= C_MAX_RD_LATENCY);
    endfunction

    // Counters must hold 0..2^addr_size inclusive.
    function automatic int cnt_width(input int addr_size);
        return addr_size + 1;
    endfunction

endpackage

// File: rtl/mem_rd_skid_fifo.sv
// Two-entry stream buffer between the memory read path and the consumer.
// O_valid is "not empty" and O_data is always the head entry.
module mem_rd_skid_fifo #(
    parameter int C_WORDSIZE = 8
) (
    input  logic                  I_clk,
    input  logic                  I_rst,
    input  logic                  I_push,
    input  logic [C_WORDSIZE-1:0] I_data,
    input  logic                  I_pop,
    output logic [C_WORDSIZE-1:0] O_data,
    output logic                  O_valid
);

    logic [C_WORDSIZE-1:0] r_mem [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign w_do_pop  = I_pop && (r_count != 2'd0);
    assign w_do_push = I_push && ((r_count != 2'd2) || w_do_pop);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            // NOTE: storage is reset too, because O_data must read 0 out of reset.
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= I_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
        end
    end

    assign O_data  = r_mem[r_rd_ptr];
    assign O_valid = (r_count != 2'd0);

endmodule

// File: rtl/mem_burst_reader.sv
// Burst read initiator: walks a contiguous (wrapping) address range and
// streams the words out in order through a 2-entry buffer.
module mem_burst_reader
    import mem_burst_reader_pkg::*;
#(
    parameter int C_WORDSIZE   = 8,
    parameter int C_ADDRSIZE   = 10,
    parameter int C_RD_LATENCY = 0
) (
    input  logic                  I_clk,
    input  logic                  I_rst,
    input  logic                  I_start,
    input  logic [C_ADDRSIZE-1:0] I_base_addr,
    input  logic [C_ADDRSIZE:0]   I_len,
    output logic                  O_busy,
    output logic                  O_done,
    output logic [C_ADDRSIZE-1:0] O_mem_addr,
    output logic                  O_mem_ren,
    input  logic [C_WORDSIZE-1:0] I_mem_data,
    output logic [C_WORDSIZE-1:0] O_data,
    output logic                  O_valid,
    input  logic                  I_ready
);

    localparam int C_CNTW = cnt_width(C_ADDRSIZE);

    if (!latency_is_legal(C_RD_LATENCY)) begin : g_bad_latency
        $error("mem_burst_reader: C_RD_LATENCY must be 0 or 1");
    end

    rd_state_e           r_state;
    rd_state_e           w_next_state;
    logic [C_ADDRSIZE-1:0] r_addr;
    logic [C_CNTW-1:0]   r_len;
    logic [C_CNTW-1:0]   r_issue_cnt;
    logic [C_CNTW-1:0]   r_accept_cnt;
    logic [C_CNTW-1:0]   w_in_flight;
    logic [C_CNTW-1:0]   w_issue_next;
    logic [C_CNTW-1:0]   w_accept_next;
    logic                w_ren;
    logic                w_push;
    logic                w_pop;
    logic                w_valid;

    // In-flight counts words in the read pipeline as well as in the buffer,
    // so limiting it to 2 is what keeps the buffer from overflowing.
    assign w_in_flight   = r_issue_cnt - r_accept_cnt;
    assign w_issue_next  = r_issue_cnt + C_CNTW'(1);
    assign w_accept_next = r_accept_cnt + C_CNTW'(1);
    assign w_ren         = (r_state == ST_READ) && (w_in_flight < C_CNTW'(2))
                           && (r_issue_cnt < r_len);
    assign w_pop         = w_valid && I_ready;

    if (C_RD_LATENCY == 0) begin : g_lat0
        assign w_push = w_ren;
    end else begin : g_lat1
        logic r_pipe_vld;
        always_ff @(posedge I_clk) begin
            if (I_rst) r_pipe_vld <= 1'b0;
            else       r_pipe_vld <= w_ren;
        end
        assign w_push = r_pipe_vld;
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_len        <= '0;
            r_issue_cnt  <= '0;
            r_accept_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_IDLE && I_start) begin
                r_addr       <= I_base_addr;
                r_len        <= I_len;
                r_issue_cnt  <= '0;
                r_accept_cnt <= '0;
            end else begin
                if (w_ren) begin
                    r_addr      <= r_addr + C_ADDRSIZE'(1);
                    r_issue_cnt <= w_issue_next;
                end
                if (w_pop) begin
                    r_accept_cnt <= w_accept_next;
                end
            end
        end
    end

    // NOTE: default first so no path through the case can infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (I_start) w_next_state = (I_len == '0) ? ST_DONE : ST_READ;
            end
            ST_READ: begin
                if (w_ren && (w_issue_next == r_len)) w_next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_pop && (w_accept_next == r_len)) w_next_state = ST_DONE;
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    mem_rd_skid_fifo #(
        .C_WORDSIZE(C_WORDSIZE)
    ) u_fifo (
        .I_clk  (I_clk),
        .I_rst  (I_rst),
        .I_push (w_push),
        .I_data (I_mem_data),
        .I_pop  (w_pop),
        .O_data (O_data),
        .O_valid(w_valid)
    );

    assign O_valid    = w_valid;
    assign O_busy     = (r_state == ST_READ) || (r_state == ST_DRAIN);
    assign O_done     = (r_state == ST_DONE);
    assign O_mem_addr = r_addr;
    assign O_mem_ren  = w_ren;

endmodule
